// File: rtl/tlb_op_unit.sv
// tlb_op_unit: sequences TLBSRCH/RD/WR/FILL/INVTLB onto the TLB array ports and returns CSR write-back data with a done pulse.
module tlb_op_unit #(
  parameter int TLBNUM = 16,
  localparam int IW = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [2:0]    op_type,
  input  logic [4:0]    inv_op,
  input  logic [9:0]    inv_asid,
  input  logic [31:0]   inv_va,
  input  logic          flush,
  input  logic [31:0]   csr_tlbidx,
  input  logic [31:0]   csr_tlbehi,
  input  logic [31:0]   csr_tlbelo0,
  input  logic [31:0]   csr_tlbelo1,
  input  logic [9:0]    csr_asid,
  input  logic [5:0]    csr_ecode,
  output logic          tlbu_s_active,
  output logic [18:0]   tlb_s0_vppn,
  output logic          tlb_s0_va_bit12,
  output logic [9:0]    tlb_s0_asid,
  input  logic          tlb_s0_found,
  input  logic [IW-1:0] tlb_s0_index,
  output logic          tlb_we,
  output logic [IW-1:0] tlb_w_index,
  output logic          tlb_w_e,
  output logic [18:0]   tlb_w_vppn,
  output logic [5:0]    tlb_w_ps,
  output logic [9:0]    tlb_w_asid,
  output logic          tlb_w_g,
  output logic [19:0]   tlb_w_ppn0,
  output logic [1:0]    tlb_w_plv0,
  output logic [1:0]    tlb_w_mat0,
  output logic          tlb_w_d0,
  output logic          tlb_w_v0,
  output logic [19:0]   tlb_w_ppn1,
  output logic [1:0]    tlb_w_plv1,
  output logic [1:0]    tlb_w_mat1,
  output logic          tlb_w_d1,
  output logic          tlb_w_v1,
  output logic [IW-1:0] tlb_r_index,
  input  logic          tlb_r_e,
  input  logic [18:0]   tlb_r_vppn,
  input  logic [5:0]    tlb_r_ps,
  input  logic [9:0]    tlb_r_asid,
  input  logic          tlb_r_g,
  input  logic [19:0]   tlb_r_ppn0,
  input  logic [1:0]    tlb_r_plv0,
  input  logic [1:0]    tlb_r_mat0,
  input  logic          tlb_r_d0,
  input  logic          tlb_r_v0,
  input  logic [19:0]   tlb_r_ppn1,
  input  logic [1:0]    tlb_r_plv1,
  input  logic [1:0]    tlb_r_mat1,
  input  logic          tlb_r_d1,
  input  logic          tlb_r_v1,
  output logic          invtlb_valid,
  output logic [4:0]    invtlb_op,
  output logic          done,
  output logic          inv_err,
  output logic          wb_idx_we,
  output logic          wb_ehi_we,
  output logic          wb_elo_we,
  output logic          wb_asid_we,
  output logic [31:0]   wb_tlbidx,
  output logic [31:0]   wb_tlbehi,
  output logic [31:0]   wb_tlbelo0,
  output logic [31:0]   wb_tlbelo1,
  output logic [9:0]    wb_asid
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t r_state, w_next;
  logic [2:0] r_op;
  logic [4:0] r_inv_op;
  logic [9:0] r_inv_asid;
  logic [18:0] r_inv_vppn;
  logic [IW-1:0] r_fill_ptr, r_index;
  logic r_found, r_e, r_g;
  logic [18:0] r_vppn;
  logic [5:0] r_ps;
  logic [9:0] r_asid;
  logic [25:0] r_lo0, r_lo1;
  logic w_accept, w_exec, w_resp, w_srch, w_rd, w_wr, w_fill, w_inv, w_inv_ok;
  logic w_inv_go, w_s_srch, w_wsel, w_fill_commit;
  logic [31:0] w_srch_idx, w_rd_idx;
  logic w_unused;
  assign w_accept = op_valid & op_ready;
  assign w_exec = r_state == EXEC;
  assign w_resp = r_state == RESP;
  assign w_srch = r_op == 3'd0;
  assign w_rd = r_op == 3'd1;
  assign w_wr = r_op == 3'd2;
  assign w_fill = r_op == 3'd3;
  assign w_inv = r_op == 3'd4;
  assign w_inv_ok = r_inv_op <= 5'd6;
  assign w_inv_go = w_exec & w_inv & w_inv_ok;
  assign w_s_srch = w_exec & w_srch;
  assign w_wsel = w_exec & (w_wr | w_fill);
  assign w_fill_commit = w_exec & w_fill & !flush;
  always_comb begin
    w_next = (r_state == IDLE) ? (w_accept ? EXEC : IDLE) :
             (r_state == EXEC) ? (flush ? IDLE : RESP) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_op <= '0;
      r_inv_op <= '0;
      r_inv_asid <= '0;
      r_inv_vppn <= '0;
      r_fill_ptr <= '0;
      r_found <= 1'b0;
      r_index <= '0;
      r_e <= 1'b0;
      r_g <= 1'b0;
      r_vppn <= '0;
      r_ps <= '0;
      r_asid <= '0;
      r_lo0 <= '0;
      r_lo1 <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op <= op_type;
        r_inv_op <= inv_op;
        r_inv_asid <= inv_asid;
        r_inv_vppn <= inv_va[31:13];
      end
      if (w_exec) begin
        r_found <= tlb_s0_found;
        r_index <= tlb_s0_index;
        r_e <= tlb_r_e;
        r_g <= tlb_r_g;
        r_vppn <= tlb_r_vppn;
        r_ps <= tlb_r_ps;
        r_asid <= tlb_r_asid;
        r_lo0 <= {tlb_r_ppn0, tlb_r_mat0, tlb_r_plv0, tlb_r_d0, tlb_r_v0};
        r_lo1 <= {tlb_r_ppn1, tlb_r_mat1, tlb_r_plv1, tlb_r_d1, tlb_r_v1};
      end
      if (w_fill_commit)
        r_fill_ptr <= (r_fill_ptr == IW'(TLBNUM - 1)) ? '0 : r_fill_ptr + 1'b1;
    end
  end
  assign op_ready = (r_state == IDLE) & !flush & !reset;
  assign tlbu_s_active = w_s_srch | w_inv_go;
  assign tlb_s0_vppn = w_s_srch ? csr_tlbehi[31:13] : w_inv_go ? r_inv_vppn : '0;
  assign tlb_s0_asid = w_s_srch ? csr_asid : w_inv_go ? r_inv_asid : '0;
  assign tlb_s0_va_bit12 = 1'b0;
  assign tlb_r_index = (w_exec & w_rd) ? csr_tlbidx[IW-1:0] : '0;
  // Write fields are presented for the whole EXEC cycle; only the strobe honours flush.
  assign tlb_we = w_wsel & !flush;
  assign tlb_w_index = w_wsel ? (w_fill ? r_fill_ptr : csr_tlbidx[IW-1:0]) : '0;
  assign tlb_w_e = w_wsel & ((csr_ecode == 6'h3F) | ~csr_tlbidx[31]);
  assign tlb_w_vppn = w_wsel ? csr_tlbehi[31:13] : '0;
  assign tlb_w_ps = w_wsel ? csr_tlbidx[29:24] : '0;
  assign tlb_w_asid = w_wsel ? csr_asid : '0;
  assign tlb_w_g = w_wsel & csr_tlbelo0[6] & csr_tlbelo1[6];
  assign tlb_w_ppn0 = w_wsel ? csr_tlbelo0[27:8] : '0;
  assign tlb_w_plv0 = w_wsel ? csr_tlbelo0[3:2] : '0;
  assign tlb_w_mat0 = w_wsel ? csr_tlbelo0[5:4] : '0;
  assign tlb_w_d0 = w_wsel & csr_tlbelo0[1];
  assign tlb_w_v0 = w_wsel & csr_tlbelo0[0];
  assign tlb_w_ppn1 = w_wsel ? csr_tlbelo1[27:8] : '0;
  assign tlb_w_plv1 = w_wsel ? csr_tlbelo1[3:2] : '0;
  assign tlb_w_mat1 = w_wsel ? csr_tlbelo1[5:4] : '0;
  assign tlb_w_d1 = w_wsel & csr_tlbelo1[1];
  assign tlb_w_v1 = w_wsel & csr_tlbelo1[0];
  assign invtlb_valid = w_inv_go & !flush;
  assign invtlb_op = w_inv_go ? r_inv_op : '0;
  assign done = w_resp & !flush;
  assign inv_err = done & w_inv & !w_inv_ok;
  assign wb_idx_we = done & (w_srch | w_rd);
  assign wb_ehi_we = done & w_rd;
  assign wb_elo_we = done & w_rd;
  assign wb_asid_we = done & w_rd;
  assign w_srch_idx = {~r_found, csr_tlbidx[30:IW], r_found ? r_index : csr_tlbidx[IW-1:0]};
  assign w_rd_idx = {~r_e, csr_tlbidx[30], r_e ? r_ps : 6'd0, csr_tlbidx[23:0]};
  assign wb_tlbidx = wb_idx_we ? (w_rd ? w_rd_idx : w_srch_idx) : '0;
  assign wb_tlbehi = (wb_ehi_we & r_e) ? {r_vppn, 13'd0} : '0;
  assign wb_tlbelo0 = (wb_elo_we & r_e) ? {4'd0, r_lo0[25:6], 1'b0, r_g, r_lo0[5:0]} : '0;
  assign wb_tlbelo1 = (wb_elo_we & r_e) ? {4'd0, r_lo1[25:6], 1'b0, r_g, r_lo1[5:0]} : '0;
  assign wb_asid = (wb_asid_we & r_e) ? r_asid : '0;
  assign w_unused = ^{csr_tlbehi[12:0], inv_va[12:0], csr_tlbelo0[31:28], csr_tlbelo0[7],
                      csr_tlbelo1[31:28], csr_tlbelo1[7]};
endmodule

// File: doc/tlb_op_unit.md
Name: tlb_op_unit

Overview:
Initiator side of the TLB array interface. Executes TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB on behalf of the pipeline.
- Drives the TLB search port 0, read, write and invalidate ports from the CSR values and the instruction operands.
- Returns CSR write-back data (TLBIDX, TLBEHI, TLBELO0/1, ASID) with a one-cycle done pulse.
- Sits between the WB-stage TLB instruction decode and the TLB array.

Parameters:
TLBNUM, 16, number of TLB entries; index width IW = clog2(TLBNUM).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
op_valid  in  1  TLB instruction request
op_ready  out  1  unit can accept a request
op_type  in  3  0=SRCH 1=RD 2=WR 3=FILL 4=INV; others reserved
inv_op  in  5  INVTLB op field
inv_asid  in  10  rj[9:0]
inv_va  in  32  rk
flush  in  1  pipeline cancel
csr_tlbidx, csr_tlbehi, csr_tlbelo0, csr_tlbelo1  in  32 each  current CSR values
csr_asid  in  10  ASID.ASID
csr_ecode  in  6  ESTAT.Ecode
tlbu_s_active  out  1  selects this unit onto search port 0
tlb_s0_vppn/va_bit12/asid  out  19/1/10  search request
tlb_s0_found/index  in  1/IW  search result
tlb_we, tlb_w_index, tlb_w_e, tlb_w_vppn, tlb_w_ps, tlb_w_asid, tlb_w_g  out  1/IW/1/19/6/10/1  write port
tlb_w_ppn0/plv0/mat0/d0/v0, tlb_w_ppn1/plv1/mat1/d1/v1  out  20/2/2/1/1 each  write page fields
tlb_r_index  out  IW  read index
tlb_r_e/vppn/ps/asid/g/ppn0/plv0/mat0/d0/v0/ppn1/plv1/mat1/d1/v1  in  matching widths  read data
invtlb_valid, invtlb_op  out  1/5  invalidate request
done  out  1  operation committed (1 cycle)
inv_err  out  1  with done: reserved INVTLB op
wb_idx_we, wb_ehi_we, wb_elo_we, wb_asid_we  out  1 each  CSR write enables, valid only with done
wb_tlbidx, wb_tlbehi, wb_tlbelo0, wb_tlbelo1  out  32 each  CSR write data
wb_asid  out  10  ASID write data

Behaviour:
- CSR field map:
  - TLBIDX: INDEX[IW-1:0], PS[29:24], NE[31].
  - TLBEHI: VPPN[31:13].
  - TLBELO: V[0], D[1], PLV[3:2], MAT[5:4], G[6], PPN[27:8].
- FSM states IDLE, EXEC, RESP.
  - op_ready = (state==IDLE) & !flush.
  - Accept on op_valid & op_ready: latch op_type, inv_op, inv_asid, inv_va; next state EXEC.
  - EXEC lasts 1 cycle, then RESP. RESP lasts 1 cycle with done=1, then IDLE.
  - Acceptance-to-done latency: 2 cycles. Max throughput: 1 op per 3 cycles.
- All TLB-driving outputs are combinational from state and latched data, and are active only in EXEC.
- SRCH:
  - EXEC: tlbu_s_active=1; vppn = csr_tlbehi[31:13]; asid = csr_asid; va_bit12 = 0. Register found and index at end of EXEC.
  - RESP: wb_idx_we=1. On hit, NE=0 and INDEX=index. On miss, NE=1 and INDEX unchanged. Other TLBIDX bits pass through from csr_tlbidx.
- RD:
  - EXEC: tlb_r_index = csr_tlbidx[IW-1:0]. Register all r_* at end of EXEC.
  - RESP, entry valid (e=1): all four we asserted; NE=0; PS=r_ps; EHI/ELO/ASID filled from entry; G replicated into both ELO words.
  - RESP, entry invalid (e=0): NE=1; PS=0; wb_tlbehi, wb_tlbelo0/1 and wb_asid all 0.
- WR/FILL:
  - EXEC: tlb_we=1. Index = csr_tlbidx INDEX for WR, fill_ptr for FILL.
  - w_e = 1 if csr_ecode==6'h3F, else !NE.
  - w_g = elo0.G & elo1.G; w_ps = TLBIDX.PS; w_asid = csr_asid.
  - RESP: done only; no CSR write.
- fill_ptr: IW-bit register, reset 0. Increments by 1 (wraps TLBNUM-1 → 0) only on a committed FILL, i.e. the EXEC cycle with tlb_we=1.
- INV:
  - inv_op ≤ 6: EXEC asserts invtlb_valid=1 with invtlb_op=inv_op, tlbu_s_active=1, s0_vppn = inv_va[31:13], s0_asid = inv_asid.
  - inv_op > 6: no invtlb_valid; RESP asserts done with inv_err=1.
- Reserved op_type: no TLB activity; done=1 in RESP; no CSR write.
- flush:
  - In IDLE: blocks acceptance.
  - In EXEC: gates tlb_we, invtlb_valid and fill_ptr increment that same cycle; next state IDLE; no done.
  - In RESP: suppresses done and all we; next state IDLE.
- Reset (any time, including mid-operation): state=IDLE, fill_ptr=0, all registered results cleared. All outputs 0 except op_ready, which is 1 once reset deasserts.
- In IDLE/RESP all TLB request outputs are 0.

Test Plan:
1. SRCH hit: entry 5 holds vppn 0x12345, asid 3; csr_tlbehi = 0x2468A000, csr_asid = 3 → done 2 cycles after accept, wb_tlbidx NE=0, INDEX=5. Repeat with asid 4, g=0 → NE=1.
2. RD of invalid entry 9 → wb_tlbidx NE=1, PS=0; wb_tlbehi, wb_tlbelo0/1 and wb_asid all 0; all four we=1.
3. FILL ×17 → tlb_w_index sequence 0..15 then 0. csr_ecode=0x3F with NE=1 → w_e=1. A WR in between leaves fill_ptr unchanged.
4. WR with elo0.G=1, elo1.G=0, PS=22 → w_g=0, w_ps=22, single tlb_we pulse.
5. INVTLB op 5, rj=0x7, rk=0x00403000 → one-cycle invtlb_valid, s0_vppn=0x00201, s0_asid=7. INVTLB op 9 → no invtlb_valid, done with inv_err=1.
6. flush in EXEC of FILL → no tlb_we, no done, fill_ptr unchanged. Reset asserted in EXEC of WR → no write, state IDLE, fill_ptr=0.
